philv_fetch_unit: RTL and testbench
===================================

Name: philv_fetch_unit

Overview:
- Parametrised, decoupled instruction-fetch stage for the next-generation PhilosophyV core. It replaces the single PC register and direct instruction-memory read.
- Issues sequential fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions, each with its PC, in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (branch/jump) with flush, and discards responses that were in flight when the redirect occurred.

Parameters:
- BUS_WIDTH, 32, address and PC width.
- INSTR_WIDTH, 32, instruction width.
- DEPTH, 4, instruction FIFO entries. Also the maximum number of outstanding plus buffered fetches. Must be ≥ 2.
- PC_START_ADDRESS, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, PC increment per fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  load a new fetch PC and flush.
- redirect_pc  in  BUS_WIDTH  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  BUS_WIDTH  fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥ 1.
- imem_rsp_data  in  INSTR_WIDTH  fetched instruction.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  INSTR_WIDTH  head instruction.
- instr_pc  out  BUS_WIDTH  PC of head instruction.

Behaviour:
- Reset state (rst=1 at an edge):
  - fetch_pc = rsp_pc = PC_START_ADDRESS.
  - FIFO count, outstanding count and drop count = 0.
  - Outputs in the following cycle: imem_req_valid=1 (credit available), imem_req_addr=PC_START_ADDRESS, instr_valid=0.
  - Reset mid-operation abandons everything. Responses arriving after reset to pre-reset requests are not tracked; the environment must quiesce memory with reset.
- Credit and request issue:
  - credit = (fifo_count + outstanding) < DEPTH.
  - imem_req_valid = credit & !redirect_valid & !rst (combinational).
  - imem_req_addr = fetch_pc.
  - On a request handshake: fetch_pc += PC_STEP (wraps modulo 2^BUS_WIDTH) and outstanding++.
  - While imem_req_ready=0, imem_req_addr holds stable.
- Response handling:
  - If drop_count > 0: the response is discarded, drop_count-- and outstanding--.
  - Otherwise: {imem_rsp_data, rsp_pc} is pushed into the FIFO, rsp_pc += PC_STEP and outstanding--.
  - A response while outstanding==0 is a protocol violation. It is ignored and no counter changes.
  - Credit accounting guarantees the FIFO never overflows; no full check is applied to pushes.
- Output:
  - instr_valid = (fifo_count != 0) & !redirect_valid.
  - instr and instr_pc come from the FIFO head.
  - A handshake (instr_valid & instr_ready) pops one entry.
  - Latency: a response at edge N is visible at the head from cycle N+1 when the FIFO was empty. There is no bypass.
  - Push and pop in the same cycle are allowed at any occupancy, including DEPTH; fifo_count is unchanged.
- Redirect (priority over everything except rst):
  - fetch_pc = rsp_pc = redirect_pc.
  - FIFO cleared: count=0, pointers reset.
  - drop_count = outstanding after applying this cycle's response. The same-cycle response is itself discarded and counts against outstanding.
  - No request is issued and no pop occurs in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop_count is recomputed each time.
- Counter widths: all counters are $clog2(DEPTH+1) bits. FIFO pointers are $clog2(DEPTH) bits and wrap at DEPTH, including non-power-of-2 DEPTH.
- Registers and FIFO storage need no reset; only pointers, counters and the PC registers are reset.

Test Plan:
- Reset release, always-ready memory with 1-cycle latency, instr_ready=1 → requests at 0x0, 0x4, 0x8, 0xC. instr_pc sequence 0x0, 0x4, 0x8, 0xC with matching data, one per cycle in steady state.
- instr_ready=0, DEPTH=4 → exactly 4 request handshakes, then imem_req_valid=0. fifo holds 4. Asserting instr_ready drains 0x0..0xC and fetch resumes at 0x10.
- Memory latency 3, two requests in flight (0x8, 0xC), redirect_pc=0x100 → both responses dropped. The next instr_pc is 0x100, followed by 0x104, with no stale instruction visible.
- Redirect in the same cycle as a response and a full FIFO → FIFO empties, the response is discarded, imem_req_valid=0 that cycle, and the next request address is the redirect target.
- imem_req_ready=0 for 5 cycles → imem_req_addr is stable at 0x10 and no PC advance. PC at 0xFFFF_FFFC wraps to 0x0.
- rst asserted with 3 FIFO entries and 1 outstanding → next cycle instr_valid=0 and imem_req_addr=PC_START_ADDRESS; all counters are zero.

Source files
------------

// File: rtl/philv_fetch_unit.sv
// Decoupled instruction-fetch stage: credit-limited sequential fetch, in-order
// response tracking, DEPTH-entry instruction/PC FIFO and redirect with flush.
module philv_fetch_unit #(
    parameter int unsigned           BUS_WIDTH        = 32,
    parameter int unsigned           INSTR_WIDTH      = 32,
    parameter int unsigned           DEPTH            = 4,
    parameter logic [BUS_WIDTH-1:0]  PC_START_ADDRESS = '0,
    parameter int unsigned           PC_STEP          = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [BUS_WIDTH-1:0]   redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [BUS_WIDTH-1:0]   imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [BUS_WIDTH-1:0]   instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0]           DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]         LAST_PTR = PW'(DEPTH - 1);
    localparam logic [BUS_WIDTH-1:0]  STEP_C   = BUS_WIDTH'(PC_STEP);

    logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [BUS_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]        fifo_count_q, fifo_count_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [CW-1:0]        drop_count_q, drop_count_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [BUS_WIDTH-1:0]   pc_mem_q    [DEPTH];

    logic [CW:0] in_use;
    logic        credit;
    logic        req_fire;
    logic        rsp_accept;
    logic        rsp_drop;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Every buffered or in-flight fetch holds one credit, so pushes never overflow.
    assign in_use         = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    assign credit         = in_use < DEPTH_W;
    assign imem_req_valid = credit & ~redirect_valid & ~rst;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_accept  = imem_rsp_valid & (outstanding_q != '0);
    assign rsp_drop    = rsp_accept & (drop_count_q != '0);
    assign push        = rsp_accept & ~rsp_drop & ~redirect_valid;

    assign instr_valid = (fifo_count_q != '0) & ~redirect_valid;
    assign instr       = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign pop         = instr_valid & instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        fifo_count_d  = fifo_count_q;
        outstanding_d = outstanding_q;
        drop_count_d  = drop_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (req_fire) begin
            fetch_pc_d    = fetch_pc_q + STEP_C;
            outstanding_d = outstanding_d + CW'(1);
        end
        if (rsp_accept) begin
            outstanding_d = outstanding_d - CW'(1);
        end
        if (rsp_drop) begin
            drop_count_d = drop_count_q - CW'(1);
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + STEP_C;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        // Whatever is still in flight after this cycle's response belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc;
            rsp_pc_d     = redirect_pc;
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            drop_count_d = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= PC_START_ADDRESS;
            rsp_pc_q      <= PC_START_ADDRESS;
            fifo_count_q  <= '0;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            fifo_count_q  <= fifo_count_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Directed bench for philv_fetch_unit with an in-order fixed-latency memory
// model; inputs change 1 time unit after posedge, memory reacts at negedge.
module tb_philv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    logic ready_ctrl = 1'b1;

    logic [31:0] req_log [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] pop_pc [$];
    logic [31:0] pop_data [$];
    int          pop_cyc [$];

    philv_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: a request accepted at edge e answers at edge e + mem_lat.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_req_ready = ready_ctrl;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    req_log.push_back(imem_req_addr);
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + 1 + mem_lat);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                pop_pc.push_back(instr_pc);
                pop_data.push_back(instr);
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_data.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; ready_ctrl = 1'b1; mem_lat = lat;
        tick();
        tick();
        clear_logs();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 60 && pop_pc.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b0; ready_ctrl = 1'b1; mem_lat = 1;
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_held_req_valid: got %b expected 0", imem_req_valid); end
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_held_instr_valid: got %b expected 0", instr_valid); end
        clear_logs();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_valid: got %b expected 1", imem_req_valid); end
        checks++;
        if (imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); end
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    endtask

    task automatic test_stream();
        do_reset(1);
        instr_ready = 1'b1;
        wait_pops(8);
        checks++;
        if (pop_pc.size() < 8 || req_log.size() < 4) begin
            failures++; $display("[TB] FAIL stream_count: got %0d pops expected 8", pop_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (req_log[i] !== 32'(4 * i)) begin failures++; $display("[TB] FAIL stream_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pop_pc[i] !== 32'(4 * i)) begin failures++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'(4 * i)); end
                checks++;
                if (pop_data[i] !== mem_word(32'(4 * i))) begin failures++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, pop_data[i], mem_word(32'(4 * i))); end
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (pop_cyc[i + 1] !== pop_cyc[i] + 1) begin failures++; $display("[TB] FAIL stream_rate[%0d]: got gap %0d expected 1", i, pop_cyc[i + 1] - pop_cyc[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        repeat (10) tick();
        checks++;
        if (req_log.size() !== 4) begin failures++; $display("[TB] FAIL bp_req_count: got %0d expected 4", req_log.size()); end
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        wait_pops(5);
        checks++;
        if (pop_pc.size() < 5 || req_log.size() < 5) begin
            failures++; $display("[TB] FAIL bp_drain_count: got %0d pops expected 5", pop_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pop_pc[i] !== 32'(4 * i) || pop_data[i] !== mem_word(32'(4 * i))) begin
                    failures++; $display("[TB] FAIL bp_drain[%0d]: got pc=%h data=%h expected pc=%h", i, pop_pc[i], pop_data[i], 32'(4 * i));
                end
            end
            checks++;
            if (req_log[4] !== 32'h10) begin failures++; $display("[TB] FAIL bp_resume_addr: got %h expected 00000010", req_log[4]); end
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        do_reset(3);
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pend_addr.size() == 2 && req_log.size() == 4) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("[TB] FAIL rdi_setup: got %0d in flight expected 2", pend_addr.size()); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdi_cycle: got req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("[TB] FAIL rdi_next_req: got valid=%b addr=%h expected 1 00000100", imem_req_valid, imem_req_addr); end
        wait_pops(2);
        checks++;
        if (pop_pc.size() < 2) begin
            failures++; $display("[TB] FAIL rdi_pop_count: got %0d expected 2", pop_pc.size());
        end else begin
            checks++;
            if (pop_pc[0] !== 32'h100 || pop_data[0] !== mem_word(32'h100)) begin failures++; $display("[TB] FAIL rdi_first: got pc=%h data=%h expected pc=00000100", pop_pc[0], pop_data[0]); end
            checks++;
            if (pop_pc[1] !== 32'h104 || pop_data[1] !== mem_word(32'h104)) begin failures++; $display("[TB] FAIL rdi_second: got pc=%h data=%h expected pc=00000104", pop_pc[1], pop_data[1]); end
        end
    endtask

    task automatic test_redirect_full();
        bit found = 0;
        do_reset(1);
        repeat (10) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h280;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdf_full_cycle: got req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h280) begin
            failures++; $display("[TB] FAIL rdf_full_after: got instr_valid=%b req_valid=%b addr=%h expected 0 1 00000280", instr_valid, imem_req_valid, imem_req_addr);
        end
        do_reset(3);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pend_addr.size() == 1 && req_log.size() == 4) found = 1;
        end
        checks++;
        if (!found || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL rdf_setup: got in_flight=%0d head=%h expected 1 00000000", pend_addr.size(), instr_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdf_cycle: got req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdf_rsp_discarded: got instr_valid=%b expected 0", instr_valid); end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("[TB] FAIL rdf_next_req: got valid=%b addr=%h expected 1 00000200", imem_req_valid, imem_req_addr); end
        pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
        instr_ready = 1'b1;
        wait_pops(1);
        checks++;
        if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200) begin failures++; $display("[TB] FAIL rdf_first_pop: got %0d pops expected first pc 00000200", pop_pc.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        instr_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        #1;
        pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin failures++; $display("[TB] FAIL b2b_next_req: got valid=%b addr=%h expected 1 00000400", imem_req_valid, imem_req_addr); end
        wait_pops(2);
        checks++;
        if (pop_pc.size() < 2) begin
            failures++; $display("[TB] FAIL b2b_pop_count: got %0d expected 2", pop_pc.size());
        end else begin
            checks++;
            if (pop_pc[0] !== 32'h400 || pop_data[0] !== mem_word(32'h400)) begin failures++; $display("[TB] FAIL b2b_first: got pc=%h expected 00000400", pop_pc[0]); end
            checks++;
            if (pop_pc[1] !== 32'h404) begin failures++; $display("[TB] FAIL b2b_second: got pc=%h expected 00000404", pop_pc[1]); end
        end
    endtask

    task automatic test_req_stall();
        do_reset(1);
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && req_log.size() < 4; i++) tick();
        ready_ctrl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
                failures++; $display("[TB] FAIL stall_addr[%0d]: got valid=%b addr=%h expected 1 00000010", i, imem_req_valid, imem_req_addr);
            end
        end
        checks++;
        if (req_log.size() !== 4) begin failures++; $display("[TB] FAIL stall_req_count: got %0d expected 4", req_log.size()); end
        ready_ctrl = 1'b1;
        for (int i = 0; i < 20 && req_log.size() < 6; i++) tick();
        checks++;
        if (req_log.size() < 6 || req_log[4] !== 32'h10 || req_log[5] !== 32'h14) begin
            failures++; $display("[TB] FAIL stall_resume: got %0d requests expected 00000010 then 00000014 at index 4/5", req_log.size());
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
        do_reset(1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_addr !== 32'hFFFF_FFF8) begin failures++; $display("[TB] FAIL wrap_first_req: got %h expected fffffff8", imem_req_addr); end
        wait_pops(4);
        checks++;
        if (pop_pc.size() < 4 || req_log.size() < 4) begin
            failures++; $display("[TB] FAIL wrap_pop_count: got %0d expected 4", pop_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_pc[i] !== exp_pc[i] || pop_data[i] !== mem_word(exp_pc[i]) || req_log[i] !== exp_pc[i]) begin
                    failures++; $display("[TB] FAIL wrap[%0d]: got pc=%h req=%h expected %h", i, pop_pc[i], req_log[i], exp_pc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bit found = 0;
        do_reset(3);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pend_addr.size() == 1 && req_log.size() == 4) found = 1;
        end
        checks++;
        if (!found || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_setup: got in_flight=%0d instr_valid=%b expected 1 1", pend_addr.size(), instr_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_lat = 1;
        clear_logs();
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_instr_valid: got %b expected 0", instr_valid); end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL midrst_req: got valid=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr); end
        repeat (10) tick();
        checks++;
        if (req_log.size() !== 4) begin failures++; $display("[TB] FAIL midrst_credit: got %0d requests expected 4", req_log.size()); end
        checks++;
        if (instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin failures++; $display("[TB] FAIL midrst_head: got pc=%h data=%h expected pc=00000000", instr_pc, instr); end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_back_to_back();
        test_req_stall();
        test_pc_wrap();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
